// File: rtl/hyst_array_controller.sv
// Canny hysteresis over an N_OUT-pixel window, LANES pixels per cycle, with previous-row promotion.
// Latency: capture edge to hyst_final is N_OUT/LANES+2 cycles; HYST_DIRECTIONAL_EN restricts promotion to the edge direction.
// Backpressure: none; anchor_moving/frame_start are ignored (not queued) outside IDLE.
module hyst_array_controller #(
  parameter int N_OUT = 10,
  parameter int PIX_W = 8,
  parameter int LANES = 2
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         anchor_moving,
  input  logic                         frame_start,
  input  logic [PIX_W-1:0]             low_thresh,
  input  logic [PIX_W-1:0]             high_thresh,
  input  logic [(N_OUT+2)*2-1:0]       gradient_angle,
  input  logic [(N_OUT+2)*PIX_W-1:0]   hyst_in,
  output logic [N_OUT*PIX_W-1:0]       hyst_out,
  output logic                         hyst_final,
  output logic                         busy
);

  localparam int GROUPS = N_OUT / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PROCESS,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_OUT+1:0][PIX_W-1:0] mag_q;
  logic [N_OUT+1:0][1:0]       ang_q;
  logic [PIX_W-1:0]            lo_q;
  logic [PIX_W-1:0]            hi_q;
  logic [N_OUT+1:0]            strong_q;
  logic [N_OUT-1:0]            weak_q;
  logic [N_OUT-1:0]            hist_q;
  logic [CNT_W-1:0]            cnt;
  logic [N_OUT-1:0][PIX_W-1:0] out_q;

  logic [N_OUT+1:0]            strong_c;
  logic [N_OUT-1:0]            weak_c;
  logic [N_OUT+1:0]            hist_pad;
  logic [N_OUT-1:0]            edge_c;
  logic                        qual;
  logic                        last_grp;

  assign hyst_out = out_q;
  assign busy     = (state == S_LOAD) || (state == S_PROCESS);
  assign last_grp = (cnt == CNT_W'(GROUPS - 1));

  // History indices -1 and N_OUT read as zero through the padding bits.
  assign hist_pad = {1'b0, hist_q, 1'b0};

  always_ff @(posedge clk) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (anchor_moving) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_PROCESS;
      S_PROCESS: if (last_grp) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Weak class is empty by construction when lo_q > hi_q.
  always_comb begin
    strong_c = '0;
    weak_c   = '0;
    for (int j = 0; j < N_OUT + 2; j++) begin
      strong_c[j] = (mag_q[j] >= hi_q);
    end
    for (int i = 0; i < N_OUT; i++) begin
      weak_c[i] = (mag_q[i+1] >= lo_q) && (mag_q[i+1] < hi_q);
    end
  end

  // Promotion looks only at the window strong class and the history row,
  // so a promoted weak pixel never promotes its same-row neighbour.
  always_comb begin
    edge_c = '0;
    qual   = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
`ifdef HYST_DIRECTIONAL_EN
      case (ang_q[i+1])
        2'd0:    qual = hist_pad[i+1];
        2'd1:    qual = hist_pad[i+2];
        2'd2:    qual = strong_q[i] | strong_q[i+2];
        default: qual = hist_pad[i];
      endcase
`else
      qual = strong_q[i] | strong_q[i+2] | hist_pad[i] | hist_pad[i+1] | hist_pad[i+2];
`endif
      edge_c[i] = strong_q[i+1] | (weak_q[i] & qual);
    end
  end

`ifdef HYST_DIRECTIONAL_EN
  logic unused_ang_ctx;
  assign unused_ang_ctx = ^{ang_q[0], ang_q[N_OUT+1]};
`else
  logic unused_ang;
  assign unused_ang = ^ang_q;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mag_q      <= '0;
      ang_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      strong_q   <= '0;
      weak_q     <= '0;
      hist_q     <= '0;
      cnt        <= '0;
      out_q      <= '0;
      hyst_final <= 1'b0;
    end else begin
      hyst_final <= 1'b0;
      case (state)
        S_IDLE: begin
          // Clear and capture on the same edge: the captured row sees zero history.
          if (frame_start) hist_q <= '0;
          if (anchor_moving) begin
            mag_q <= hyst_in;
            ang_q <= gradient_angle;
            lo_q  <= low_thresh;
            hi_q  <= high_thresh;
          end
        end
        S_LOAD: begin
          strong_q <= strong_c;
          weak_q   <= weak_c;
          cnt      <= '0;
        end
        S_PROCESS: begin
          for (int i = 0; i < N_OUT; i++) begin
            if ((i / LANES) == int'(cnt)) out_q[i] <= edge_c[i] ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
          end
          cnt <= cnt + 1'b1;
        end
        S_DONE: begin
          hyst_final <= 1'b1;
          for (int i = 0; i < N_OUT; i++) begin
            hist_q[i] <= |out_q[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyst_array_controller.sv
// Randomized and directed checks of hyst_array_controller against a per-pixel rule model.
module tb_hyst_array_controller;

  localparam int N  = 10;
  localparam int PW = 8;
  localparam int L  = 2;

  logic                   tb_clk = 1'b0;
  logic                   n_rst;
  logic                   anchor_moving;
  logic                   frame_start;
  logic [PW-1:0]          low_thresh;
  logic [PW-1:0]          high_thresh;
  logic [(N+2)*2-1:0]     gradient_angle;
  logic [(N+2)*PW-1:0]    hyst_in;
  logic [N*PW-1:0]        hyst_out;
  logic                   hyst_final;
  logic                   busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: window, thresholds, previous-row edges, expected row.
  int m_mag [N+2];
  int m_ang [N+2];
  int m_lo;
  int m_hi;
  bit m_hist [N];
  bit m_exp  [N];

  hyst_array_controller #(.N_OUT(N), .PIX_W(PW), .LANES(L)) dut (
    .clk            (tb_clk),
    .n_rst          (n_rst),
    .anchor_moving  (anchor_moving),
    .frame_start    (frame_start),
    .low_thresh     (low_thresh),
    .high_thresh    (high_thresh),
    .gradient_angle (gradient_angle),
    .hyst_in        (hyst_in),
    .hyst_out       (hyst_out),
    .hyst_final     (hyst_final),
    .busy           (busy)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, observed hang, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hist_at(int k);
    if (k < 0 || k >= N) return 1'b0;
    return m_hist[k];
  endfunction

  function automatic bit strong_at(int j);
    return m_mag[j] >= m_hi;
  endfunction

  task automatic compute_expected();
    for (int i = 0; i < N; i++) begin
      int j;
      bit nb;
      j = i + 1;
`ifdef HYST_DIRECTIONAL_EN
      case (m_ang[j])
        0:       nb = hist_at(i);
        1:       nb = hist_at(i + 1);
        2:       nb = strong_at(j - 1) || strong_at(j + 1);
        default: nb = hist_at(i - 1);
      endcase
`else
      nb = strong_at(j - 1) || strong_at(j + 1) || hist_at(i - 1) || hist_at(i) || hist_at(i + 1);
`endif
      if (strong_at(j))                           m_exp[i] = 1'b1;
      else if (m_mag[j] >= m_lo && m_mag[j] < m_hi) m_exp[i] = nb;
      else                                        m_exp[i] = 1'b0;
    end
  endtask

  function automatic logic [N*PW-1:0] exp_vec();
    logic [N*PW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = m_exp[i] ? {PW{1'b1}} : {PW{1'b0}};
    return v;
  endfunction

  task automatic set_uniform(input int mag, input int ang);
    for (int j = 0; j < N + 2; j++) begin
      m_mag[j] = mag;
      m_ang[j] = ang;
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < N; i++) m_hist[i] = 1'b0;
  endtask

  task automatic scramble_inputs();
    hyst_in        = {$urandom, $urandom, $urandom};
    gradient_angle = 24'($urandom);
    low_thresh     = PW'($urandom);
    high_thresh    = PW'($urandom);
  endtask

  // One window through the DUT; optionally pokes anchor_moving/frame_start while busy.
  task automatic run_window(input string tag, input bit fs, input bit poke_busy);
    int k;
    @(negedge tb_clk);
    for (int j = 0; j < N + 2; j++) begin
      hyst_in[j*PW +: PW]   = PW'(m_mag[j]);
      gradient_angle[j*2 +: 2] = 2'(m_ang[j]);
    end
    low_thresh    = PW'(m_lo);
    high_thresh   = PW'(m_hi);
    frame_start   = fs;
    anchor_moving = 1'b1;
    if (fs) clear_hist();
    compute_expected();
    @(posedge tb_clk);
    @(negedge tb_clk);
    anchor_moving = 1'b0;
    frame_start   = 1'b0;
    scramble_inputs();
    k = 0;
    while (k < 30) begin
      @(posedge tb_clk);
      k++;
      @(negedge tb_clk);
      if (k == 1) check({tag, " busy_load"}, 128'(busy), 128'(1));
      if (hyst_final) break;
      if (poke_busy && (k == 2 || k == 4)) begin
        anchor_moving = 1'b1;
        frame_start   = 1'b1;
        scramble_inputs();
      end else begin
        anchor_moving = 1'b0;
        frame_start   = 1'b0;
      end
    end
    anchor_moving = 1'b0;
    frame_start   = 1'b0;
    check({tag, " latency"}, 128'(k), 128'(N / L + 2));
    check({tag, " hyst_out"}, 128'(hyst_out), 128'(exp_vec()));
    for (int i = 0; i < N; i++) m_hist[i] = m_exp[i];
    @(posedge tb_clk);
    @(negedge tb_clk);
    check({tag, " final_pulse"}, 128'(hyst_final), 128'(0));
    check({tag, " busy_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int finals;
    n_rst = 1'b0;
    anchor_moving = 1'b0;
    frame_start = 1'b0;
    low_thresh = '0;
    high_thresh = '0;
    gradient_angle = '0;
    hyst_in = '0;
    m_lo = 50;
    m_hi = 150;
    clear_hist();
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    check("reset hyst_out", 128'(hyst_out), 128'(0));
    check("reset hyst_final", 128'(hyst_final), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    n_rst = 1'b1;

    set_uniform(30, 0);  run_window("t1 all30", 1'b0, 1'b0);
    set_uniform(100, 1); run_window("t2 all100", 1'b0, 1'b0);
    set_uniform(200, 2); run_window("t3 all200", 1'b0, 1'b0);
    set_uniform(100, 3); run_window("t3 promote", 1'b0, 1'b0);
    set_uniform(30, 0);  run_window("t3 all30", 1'b0, 1'b0);

    set_uniform(200, 0); run_window("t4 all200", 1'b0, 1'b0);
    set_uniform(100, 0); run_window("t4 fs_capture", 1'b1, 1'b0);
    set_uniform(100, 1); m_mag[5] = 200;
    run_window("t4 single_strong", 1'b0, 1'b0);

    // frame_start alone in IDLE clears the row history.
    set_uniform(200, 0); run_window("t4b all200", 1'b0, 1'b0);
    @(negedge tb_clk);
    frame_start = 1'b1;
    @(posedge tb_clk);
    @(negedge tb_clk);
    frame_start = 1'b0;
    clear_hist();
    set_uniform(100, 0); run_window("t4b fs_alone", 1'b0, 1'b0);

    // Reset in the middle of PROCESS after history was all ones.
    set_uniform(200, 0); run_window("t5 all200", 1'b0, 1'b0);
    set_uniform(100, 0);
    @(negedge tb_clk);
    for (int j = 0; j < N + 2; j++) hyst_in[j*PW +: PW] = PW'(m_mag[j]);
    low_thresh = PW'(m_lo);
    high_thresh = PW'(m_hi);
    anchor_moving = 1'b1;
    repeat (3) begin
      @(posedge tb_clk);
      @(negedge tb_clk);
      anchor_moving = 1'b0;
    end
    n_rst = 1'b0;
    @(posedge tb_clk);
    @(negedge tb_clk);
    check("t5 rst hyst_out", 128'(hyst_out), 128'(0));
    check("t5 rst busy", 128'(busy), 128'(0));
    check("t5 rst hyst_final", 128'(hyst_final), 128'(0));
    n_rst = 1'b1;
    clear_hist();
    finals = 0;
    repeat (12) begin
      @(posedge tb_clk);
      @(negedge tb_clk);
      if (hyst_final) finals++;
    end
    check("t5 no_final_after_rst", 128'(finals), 128'(0));
    set_uniform(100, 0); run_window("t5 hist_cleared", 1'b0, 1'b0);
    set_uniform(200, 0); run_window("t5 poke_busy", 1'b0, 1'b1);
    finals = 0;
    repeat (15) begin
      @(posedge tb_clk);
      @(negedge tb_clk);
      if (hyst_final) finals++;
    end
    check("t5 no_queued_final", 128'(finals), 128'(0));
    set_uniform(100, 0); run_window("t5 fs_ignored", 1'b0, 1'b0);

`ifdef HYST_DIRECTIONAL_EN
    set_uniform(200, 0); run_window("t6 all200", 1'b0, 1'b0);
    set_uniform(100, 2); run_window("t6 angle2", 1'b0, 1'b0);
    set_uniform(200, 0); run_window("t6 all200b", 1'b0, 1'b0);
    set_uniform(100, 0); run_window("t6 angle0", 1'b0, 1'b0);
`endif

    // Random windows, thresholds (including low > high) and frame starts.
    for (int t = 0; t < 40; t++) begin
      m_lo = int'($urandom_range(0, 255));
      m_hi = int'($urandom_range(0, 255));
      for (int j = 0; j < N + 2; j++) begin
        m_mag[j] = int'($urandom_range(0, 255));
        m_ang[j] = int'($urandom_range(0, 3));
      end
      run_window("rand", ($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
